// File: rtl/chc2442_spi_pkg.sv
// Shared constants and FSM state type for the CHC2442 SPI responder.
package chc2442_spi_pkg;

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned CMD_W   = 16;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 8;

  // Field positions within the full 24-bit frame (MSB first on the wire).
  localparam int unsigned RW_BIT   = 23;
  localparam int unsigned ADDR_MSB = 22;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // The same fields as seen in the 16-bit command shift register.
  localparam int unsigned CMD_RW_BIT   = RW_BIT - DATA_W;
  localparam int unsigned CMD_ADDR_MSB = ADDR_MSB - DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE,
    WAIT_SEN
  } state_t;

endpackage

// File: rtl/chc2442_spi_edge_sync.sv
// Synchronizes SCLK, SEN and SDI into clk and flags SCLK/SEN edges.
// Chains reset low so a SEN held low across reset never looks like a
// falling edge; a new frame therefore needs SEN to be seen high first.
module chc2442_spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk_i,
  input  logic spi_sen_i,
  input  logic spi_sdata_i,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sen_fall,
  output logic sen_rise,
  output logic sen_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sen_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_d;
  logic                   sen_d;

  // Synchronizer chains plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      sen_sync  <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      sen_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi_sen_i};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdata_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      sen_d     <= sen_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
  assign sen_rise  = sen_sync[SYNC_STAGES-1] & ~sen_d;
  assign sen_fall  = ~sen_sync[SYNC_STAGES-1] & sen_d;
  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/chc2442_spi_responder.sv
// CHC2442 SPI device model: shadow register file, read-back on SDO,
// write-commit reporting to fabric.
// Optional macro CHC2442_RESP_ERRCNT_EN adds a saturating aborted-frame
// counter (err_cnt_o) with synchronous clear (err_clr_i).
module chc2442_spi_responder
  import chc2442_spi_pkg::*;
#(
  parameter int unsigned REG_AW      = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RST_VAL     = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk_i,
  input  logic              spi_sen_i,
  input  logic              spi_sdata_i,
  output logic              spi_sdout_o,
  output logic              wr_vld_o,
  output logic [14:0]       wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              rd_vld_o,
  input  logic [REG_AW-1:0] lcl_addr_i,
  output logic [7:0]        lcl_rdata_o,
  output logic              frame_err_o
`ifdef CHC2442_RESP_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt_o,
  input  logic              err_clr_i
`endif
);

  logic sclk_rise, sclk_fall, sen_fall, sen_rise, sen_s, sdi_s;

  chc2442_spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .spi_clk_i  (spi_clk_i),
    .spi_sen_i  (spi_sen_i),
    .spi_sdata_i(spi_sdata_i),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .sen_fall   (sen_fall),
    .sen_rise   (sen_rise),
    .sen_s      (sen_s),
    .sdi_s      (sdi_s)
  );

  state_t              state, state_nxt;
  logic [4:0]          bit_cnt;
  logic [CMD_W-1:0]    cmd_shift;
  logic [DATA_W-1:0]   data_shift;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   shadow [1 << REG_AW];

  logic                cmd_last;
  logic                frame_done;
  logic                abort;

  logic [CMD_W-1:0]    cmd_next;
  logic [DATA_W-1:0]   data_next;
  logic                cmd_in_range;
  logic                wr_in_range;

  assign cmd_next     = {cmd_shift[CMD_W-2:0], sdi_s};
  assign data_next    = {data_shift[DATA_W-2:0], sdi_s};
  assign cmd_in_range = ~|cmd_next[CMD_ADDR_MSB:REG_AW];
  assign wr_in_range  = ~|wr_addr_o[ADDR_W-1:REG_AW];
  assign lcl_rdata_o  = shadow[lcl_addr_i];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and frame event decode; the 24th edge wins over a SEN release.
  always_comb begin
    state_nxt  = state;
    cmd_last   = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: if (sen_fall) state_nxt = CMD;
      CMD: begin
        if (sen_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 5'(CMD_W - 1)) begin
          cmd_last  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (sclk_rise && bit_cnt == 5'(FRAME_W - 1)) begin
          frame_done = 1'b1;
          state_nxt  = DONE;
        end else if (sen_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:     state_nxt = WAIT_SEN;
      WAIT_SEN: if (sen_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shift registers, SDO, fabric pulses and the shadow register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      cmd_shift   <= '0;
      data_shift  <= '0;
      tx_shift    <= '0;
      spi_sdout_o <= 1'b0;
      wr_vld_o    <= 1'b0;
      rd_vld_o    <= 1'b0;
      frame_err_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int unsigned i = 0; i < (1 << REG_AW); i++) shadow[i] <= RST_VAL;
    end else begin
      wr_vld_o    <= 1'b0;
      rd_vld_o    <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          spi_sdout_o <= 1'b0;
          if (sen_fall) bit_cnt <= '0;
        end
        CMD: begin
          if (abort) begin
            frame_err_o <= 1'b1;
            spi_sdout_o <= 1'b0;
          end else if (sclk_rise) begin
            cmd_shift <= cmd_next;
            bit_cnt   <= bit_cnt + 5'd1;
            if (cmd_last) begin
              data_shift <= '0;
              tx_shift   <= (cmd_next[CMD_RW_BIT] && cmd_in_range) ?
                            shadow[cmd_next[REG_AW-1:0]] : '0;
            end
          end
        end
        DATA: begin
          if (frame_done) begin
            data_shift <= data_next;
            bit_cnt    <= bit_cnt + 5'd1;
            if (cmd_shift[CMD_RW_BIT]) begin
              rd_vld_o <= 1'b1;
            end else begin
              wr_vld_o  <= 1'b1;
              wr_addr_o <= cmd_shift[CMD_ADDR_MSB:0];
              wr_data_o <= data_next;
            end
          end else if (abort) begin
            frame_err_o <= 1'b1;
            spi_sdout_o <= 1'b0;
          end else begin
            if (sclk_rise) begin
              data_shift <= data_next;
              bit_cnt    <= bit_cnt + 5'd1;
            end
            if (sclk_fall) begin
              spi_sdout_o <= tx_shift[DATA_W-1];
              tx_shift    <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (!cmd_shift[CMD_RW_BIT] && wr_in_range)
            shadow[wr_addr_o[REG_AW-1:0]] <= wr_data_o;
        end
        WAIT_SEN: begin
          if (sen_s) spi_sdout_o <= 1'b0;
        end
        default: spi_sdout_o <= 1'b0;
      endcase
    end
  end

`ifdef CHC2442_RESP_ERRCNT_EN
  // Saturating count of aborted frames; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr_i)                 err_cnt_o <= '0;
    else if (frame_err_o && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chc2442_spi_responder.sv
// Scoreboard bench for chc2442_spi_responder: frames are driven at 10 MHz
// SCLK, expected fabric events are queued at drive time and popped by a
// monitor as the DUT pulses wr_vld_o / rd_vld_o / frame_err_o.
module tb_chc2442_spi_responder;
  import chc2442_spi_pkg::*;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk_i = 1'b0;
  logic        spi_sen_i = 1'b1;
  logic        spi_sdata_i = 1'b0;
  logic        spi_sdout_o;
  logic        wr_vld_o;
  logic [14:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        rd_vld_o;
  logic [5:0]  lcl_addr_i = '0;
  logic [7:0]  lcl_rdata_o;
  logic        frame_err_o;
`ifdef CHC2442_RESP_ERRCNT_EN
  logic [15:0] err_cnt_o;
  logic        err_clr_i = 1'b0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        exp_q[$];
  logic [7:0]  model_regs [64];
  exp_t        mon_e;
  logic [1:0]  mon_kind;

  chc2442_spi_responder #(
    .REG_AW     (6),
    .SYNC_STAGES(2),
    .RST_VAL    (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk_i  (spi_clk_i),
    .spi_sen_i  (spi_sen_i),
    .spi_sdata_i(spi_sdata_i),
    .spi_sdout_o(spi_sdout_o),
    .wr_vld_o   (wr_vld_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .rd_vld_o   (rd_vld_o),
    .lcl_addr_i (lcl_addr_i),
    .lcl_rdata_o(lcl_rdata_o),
    .frame_err_o(frame_err_o)
`ifdef CHC2442_RESP_ERRCNT_EN
    ,
    .err_cnt_o  (err_cnt_o),
    .err_clr_i  (err_clr_i)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every event pulse cycle must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (wr_vld_o || rd_vld_o || frame_err_o)) begin
      vectors++;
      mon_kind = wr_vld_o ? K_WR : (rd_vld_o ? K_RD : K_ERR);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected: got kind=%0d addr=%h data=%h, required no event",
                 mon_kind, wr_addr_o, wr_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_kind !== mon_e.kind ||
            (mon_kind == K_WR && (wr_addr_o !== mon_e.addr || wr_data_o !== mon_e.data))) begin
          miscompares++;
          $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                   mon_kind, wr_addr_o, wr_data_o, mon_e.kind, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input logic [1:0] kind, input logic [14:0] addr,
                                   input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    if (kind == K_WR && addr < 15'd64) model_regs[addr[5:0]] = data;
  endfunction

  // Controller model: CPOL=0, MOSI set while SCLK low, MISO sampled just
  // before each rising edge. rst_at pulses rst before that bit; sen_with_last
  // releases SEN together with the 24th rising edge.
  task automatic spi_frame(input logic [23:0] frame, input int nbits, input int rst_at,
                           input bit sen_with_last, output logic [7:0] sdo_byte);
    logic [23:0] f;
    f = frame;
    sdo_byte = '0;
    spi_sen_i = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
      spi_sdata_i = (i < 24) ? f[23 - i] : 1'b0;
      #50;
      if (i >= 16 && i < 24) sdo_byte = {sdo_byte[6:0], spi_sdout_o};
      spi_clk_i = 1'b1;
      if (sen_with_last && i == FRAME_W - 1) spi_sen_i = 1'b1;
      #50;
      spi_clk_i = 1'b0;
    end
    #100;
    spi_sen_i = 1'b1;
    #300;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_missing_events: %0d still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({wr_vld_o, rd_vld_o, frame_err_o, spi_sdout_o, wr_addr_o, wr_data_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: wr=%b rd=%b err=%b sdo=%b addr=%h data=%h, required all 0",
               wr_vld_o, rd_vld_o, frame_err_o, spi_sdout_o, wr_addr_o, wr_data_o);
    end
    for (int a = 0; a < 64; a += 21) begin
      lcl_addr_i = 6'(a);
      #1;
      vectors++;
      if (lcl_rdata_o !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_reg[%0d]: got %h, required 00", a, lcl_rdata_o);
      end
    end
    for (int a = 0; a < 64; a++) model_regs[a] = 8'h00;
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_write;
    logic [7:0] sdo;
    logic [5:0] a;
    logic [7:0] d;
    push_exp(K_WR, 15'd5, 8'h12);
    spi_frame(24'h000512, 24, -1, 1'b0, sdo);
    drain("write");
    lcl_addr_i = 6'd5;
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'h12) begin
      miscompares++;
      $display("FAIL write_reg5: got %h, required 12", lcl_rdata_o);
    end
    for (int k = 0; k < 5; k++) begin
      a = 6'($urandom_range(63));
      d = 8'($urandom);
      push_exp(K_WR, {9'd0, a}, d);
      spi_frame({1'b0, 9'd0, a, d}, 24, -1, 1'b0, sdo);
      lcl_addr_i = a;
      #1;
      vectors++;
      if (lcl_rdata_o !== model_regs[a]) begin
        miscompares++;
        $display("FAIL write_rand_reg[%0d]: got %h, required %h", a, lcl_rdata_o, model_regs[a]);
      end
    end
    drain("write_rand");
  endtask

  task automatic test_read;
    logic [7:0] sdo;
    push_exp(K_WR, 15'd5, 8'hA5);
    spi_frame(24'h0005A5, 24, -1, 1'b0, sdo);
    push_exp(K_RD, 15'd5, 8'h00);
    spi_frame(24'h800500, 24, -1, 1'b0, sdo);
    vectors++;
    if (sdo !== 8'hA5) begin
      miscompares++;
      $display("FAIL read_sdo_addr5: got %h, required a5", sdo);
    end
    push_exp(K_WR, 15'd62, 8'h3C);
    spi_frame({1'b0, 15'd62, 8'h3C}, 24, -1, 1'b0, sdo);
    push_exp(K_RD, 15'd62, 8'h00);
    spi_frame({1'b1, 15'd62, 8'hFF}, 24, -1, 1'b0, sdo);
    vectors++;
    if (sdo !== 8'h3C) begin
      miscompares++;
      $display("FAIL read_sdo_addr62: got %h, required 3c", sdo);
    end
    vectors++;
    if (spi_sdout_o !== 1'b0) begin
      miscompares++;
      $display("FAIL read_sdo_idle: got %b, required 0", spi_sdout_o);
    end
    drain("read");
  endtask

  task automatic test_out_of_range;
    logic [7:0] sdo;
    push_exp(K_WR, 15'd0, 8'hE7);
    spi_frame(24'h0000E7, 24, -1, 1'b0, sdo);
    push_exp(K_RD, 15'h7FFF, 8'h00);
    spi_frame(24'hFFFF00, 24, -1, 1'b0, sdo);
    vectors++;
    if (sdo !== 8'h00) begin
      miscompares++;
      $display("FAIL oor_read_sdo: got %h, required 00", sdo);
    end
    push_exp(K_WR, 15'h0100, 8'h5A);
    spi_frame(24'h01005A, 24, -1, 1'b0, sdo);
    drain("oor");
    for (int a = 0; a < 64; a++) begin
      lcl_addr_i = 6'(a);
      #1;
      vectors++;
      if (lcl_rdata_o !== model_regs[a]) begin
        miscompares++;
        $display("FAIL oor_reg[%0d]: got %h, required %h", a, lcl_rdata_o, model_regs[a]);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] sdo;
    push_exp(K_ERR, 15'd0, 8'h00);
    spi_frame(24'h000B77, 12, -1, 1'b0, sdo);
    drain("abort");
    lcl_addr_i = 6'd11;
    #1;
    vectors++;
    if (lcl_rdata_o !== model_regs[11]) begin
      miscompares++;
      $display("FAIL abort_reg11: got %h, required %h", lcl_rdata_o, model_regs[11]);
    end
`ifdef CHC2442_RESP_ERRCNT_EN
    vectors++;
    if (err_cnt_o !== 16'd1) begin
      miscompares++;
      $display("FAIL abort_errcnt: got %0d, required 1", err_cnt_o);
    end
`endif
    push_exp(K_WR, 15'd11, 8'h9D);
    spi_frame(24'h000B9D, 24, -1, 1'b0, sdo);
    drain("abort_next");
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'h9D) begin
      miscompares++;
      $display("FAIL abort_next_reg11: got %h, required 9d", lcl_rdata_o);
    end
`ifdef CHC2442_RESP_ERRCNT_EN
    @(negedge clk) err_clr_i = 1'b1;
    @(negedge clk) err_clr_i = 1'b0;
    vectors++;
    if (err_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL errcnt_clear: got %0d, required 0", err_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] sdo;
    push_exp(K_WR, 15'd9, 8'h3C);
    spi_frame(24'h00093C, 24, -1, 1'b0, sdo);
    drain("rstmid_pre");
    spi_frame(24'h000977, 24, 20, 1'b0, sdo);
    for (int a = 0; a < 64; a++) model_regs[a] = 8'h00;
    lcl_addr_i = 6'd9;
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_reg9: got %h, required 00", lcl_rdata_o);
    end
    push_exp(K_WR, 15'd9, 8'h66);
    spi_frame(24'h000966, 24, -1, 1'b0, sdo);
    drain("rstmid_next");
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'h66) begin
      miscompares++;
      $display("FAIL rstmid_next_reg9: got %h, required 66", lcl_rdata_o);
    end
  endtask

  task automatic test_extra_edges;
    logic [7:0] sdo;
    push_exp(K_WR, 15'h21, 8'hC3);
    spi_frame(24'h0021C3, 26, -1, 1'b0, sdo);
    drain("extra_edges");
    lcl_addr_i = 6'h21;
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'hC3) begin
      miscompares++;
      $display("FAIL extra_edges_reg33: got %h, required c3", lcl_rdata_o);
    end
  endtask

  task automatic test_sen_with_last_edge;
    logic [7:0] sdo;
    push_exp(K_WR, 15'd10, 8'h5E);
    spi_frame(24'h000A5E, 24, -1, 1'b1, sdo);
    drain("sen_last");
    lcl_addr_i = 6'd10;
    #1;
    vectors++;
    if (lcl_rdata_o !== 8'h5E) begin
      miscompares++;
      $display("FAIL sen_last_reg10: got %h, required 5e", lcl_rdata_o);
    end
    push_exp(K_RD, 15'd10, 8'h00);
    spi_frame(24'h800A00, 24, -1, 1'b0, sdo);
    drain("sen_last_read");
    vectors++;
    if (sdo !== 8'h5E) begin
      miscompares++;
      $display("FAIL sen_last_read_sdo: got %h, required 5e", sdo);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_abort();
    test_reset_mid_frame();
    test_extra_edges();
    test_sen_with_last_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chc2442_spi_responder.md
Name: chc2442_spi_responder

Overview:
- Synthesizable SPI slave. It implements the device end of the CHC2442 3-wire-plus-SDO serial protocol driven by the PL SPI controller.
- Holds a shadow register file and answers read frames on SDO. Reports every completed write to fabric.
- Used for PL loopback self-test of the controller path and as a board-less stand-in for the CHC2442 in system simulation.
- Fully synchronous to the system clock; it oversamples the SPI pins.

Parameters:
- REG_AW, 6: implemented register address bits; register file depth is 2^REG_AW.
- SYNC_STAGES, 2: synchronizer flops on spi_clk_i / spi_sen_i / spi_sdata_i (legal range 2–3).
- RST_VAL, 8'h00: reset value of every shadow register.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- spi_clk_i  in  1  SCLK from controller
- spi_sen_i  in  1  chip enable, active low
- spi_sdata_i  in  1  serial data in (controller MOSI)
- spi_sdout_o  out  1  serial data out to controller
- wr_vld_o  out  1  one-cycle pulse: write frame committed
- wr_addr_o  out  15  address of committed write
- wr_data_o  out  8  data of committed write
- rd_vld_o  out  1  one-cycle pulse: read frame completed
- lcl_addr_i  in  REG_AW  fabric read address into shadow registers
- lcl_rdata_o  out  8  shadow register contents at lcl_addr_i (combinational read)
- frame_err_o  out  1  one-cycle pulse: frame aborted

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. On reset:
  - all outputs 0, spi_sdout_o = 0;
  - state IDLE, bit counter 0;
  - all shadow registers = RST_VAL.
  - A reset mid-frame discards the frame. The responder then waits for spi_sen_i high before accepting a new frame.
- Frame format: 24 bits, MSB first.
  - bit23 = R/W (1 = read);
  - bits22:8 = address;
  - bits7:0 = data.
- Sampling and driving:
  - Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK.
  - SDI is sampled on the SCLK rising edge.
  - SDO is updated on the SCLK falling edge.
  - Requirement: SCLK high and low time ≥ SYNC_STAGES+2 clk cycles (10 MHz SCLK meets this).
- FSM:
  - IDLE: SEN falling edge → CMD, counter = 0.
  - CMD: shift 16 bits (R/W + addr); after the 16th rising edge → DATA.
    - Read: load tx_shift with reg[addr[REG_AW-1:0]]. If addr ≥ 2^REG_AW, load 8'h00.
    - Write: tx_shift = 0.
  - DATA: 8 more rising edges.
    - Read: spi_sdout_o = tx_shift[7] from the falling edge after bit 16, shifting left on each falling edge.
    - Write: SDI is shifted into the data register.
    - After the 24th rising edge → DONE.
  - DONE:
    - Write: commit reg[addr] = data, but only if addr < 2^REG_AW; out-of-range writes are dropped, wr_vld_o still pulses.
    - wr_vld_o (write) or rd_vld_o (read) pulses exactly one clk after the 24th rising edge, with wr_addr_o/wr_data_o valid that cycle and held until the next commit.
    - → WAIT_SEN.
  - WAIT_SEN: extra SCLK edges are ignored. SEN rising → IDLE, spi_sdout_o = 0.
- Abort: SEN rises in CMD or DATA.
  - Frame discarded, no register write, frame_err_o pulses, → IDLE.
- SEN falling while in WAIT_SEN is not a new frame. A frame must start from IDLE.
- Simultaneous SEN rise and the 24th rising SCLK edge in the same clk: the frame counts as complete. DONE takes priority.
- lcl_rdata_o reflects a commit on the clk after wr_vld_o.

Optional Feature:
- Macro: CHC2442_RESP_ERRCNT_EN.
- When defined:
  - adds output err_cnt_o [15:0], reset 0;
  - increments on each frame_err_o pulse and saturates at 16'hFFFF;
  - adds input err_clr_i, which clears it synchronously; clear wins over a simultaneous increment.
- Without the macro: no counter, no ports; frame_err_o is unchanged.

Decomposition:
- Package chc2442_spi_pkg:
  - FRAME_W = 24, CMD_W = 16, ADDR_W = 15, DATA_W = 8;
  - field bit positions;
  - FSM state enum {IDLE, CMD, DATA, DONE, WAIT_SEN}.
- Sub-module chc2442_spi_edge_sync:
  - synchronizer chain for the three inputs;
  - outputs sclk_rise, sclk_fall, sen_fall, sen_rise, sdi_s.
  - Instantiated once.

Test Plan:
- Write frame 0x000512 (addr 5, data 0x12) at 10 MHz → wr_vld_o 1 cycle, wr_addr_o = 5, wr_data_o = 0x12, lcl_rdata_o(5) = 0x12.
- Write addr 5 = 0xA5, then read frame 0x800500 → SDO bits 16..23 = 10100101, rd_vld_o pulses, no wr_vld_o.
- Read addr 0x7FFF (out of range) → SDO = 0x00; write to 0x0100 → wr_vld_o pulses, no register changes.
- SEN released after 12 bits → frame_err_o pulses, no write. Next full frame decodes correctly; with the macro, err_cnt_o = 1.
- rst asserted at bit 20 of a write → register unchanged, no wr_vld_o. A frame started after SEN high decodes correctly.
- 26 SCLK edges in one SEN window → only the first 24 are used, a single commit occurs.
